// File: rtl/add_approx_pkg.sv
// Shared types and helpers for the pipelined approximate adder.
// Stage records use a fixed maximum width; unused upper bits fold away in synthesis.
package add_approx_pkg;

  localparam int unsigned MAX_STAGES = 4;
  localparam int unsigned MAX_W      = 64;

  typedef struct packed {
    logic             valid;
    logic             exact;
    logic             carry;
    logic [MAX_W-1:0] sum_part;
    logic [MAX_W-1:0] a_rem;
    logic [MAX_W-1:0] b_rem;
  } stage_t;

  function automatic logic [MAX_W-1:0] low_mask(input int unsigned k);
    return (MAX_W'(1) << k) - MAX_W'(1);
  endfunction

  // Even bits come from a, odd bits from b; no carries inside the low field.
  function automatic logic [MAX_W-1:0] approx_low(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b,
                                                  input int unsigned      k);
    logic [MAX_W-1:0] even_bits;
    even_bits = {(MAX_W / 2){2'b01}};
    return ((a & even_bits) | (b & ~even_bits)) & low_mask(k);
  endfunction

  function automatic logic est_carry(input logic [MAX_W-1:0] a,
                                     input logic [MAX_W-1:0] b,
                                     input int unsigned      k);
    logic [MAX_W-1:0] both;
    if (k == 0) return 1'b0;
    both = (a & b) >> (k - 1);
    return both[0];
  endfunction

  function automatic int unsigned chunk_w(input int unsigned width,
                                          input int unsigned k,
                                          input int unsigned stages);
    return (width + 1 - k + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// One pipeline slice: adds a ChunkW-bit operand chunk with the registered carry,
// deposits the result at Offset and shifts the unconsumed operand bits down.
module add_pipe_stage
  import add_approx_pkg::*;
#(
  parameter int unsigned Offset = 0,
  parameter int unsigned ChunkW = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  stage_t stage_i,
  output stage_t stage_o
);

  logic [ChunkW:0] chunk_sum;
  stage_t          stage_d, stage_q;

  always_comb begin
    chunk_sum = {1'b0, stage_i.a_rem[ChunkW-1:0]} + {1'b0, stage_i.b_rem[ChunkW-1:0]}
              + {{ChunkW{1'b0}}, stage_i.carry};
    stage_d          = stage_i;
    stage_d.carry    = chunk_sum[ChunkW];
    stage_d.sum_part = stage_i.sum_part | (MAX_W'(chunk_sum[ChunkW-1:0]) << Offset);
    stage_d.a_rem    = stage_i.a_rem >> ChunkW;
    stage_d.b_rem    = stage_i.b_rem >> ChunkW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/add_approx_pipe.sv
// Pipelined approximate adder with valid/ready streams and per-transaction exact mode.
// Define ERRSTAT_EN to add an exact shadow pipeline and error statistics counters.
module add_approx_pipe
  import add_approx_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned APPROX_LSB = 4,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_exact
`ifdef ERRSTAT_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_samples,
  output logic [CNT_W-1:0] stat_err_cnt,
  output logic [WIDTH:0]   stat_max_err
`endif
);

  localparam int unsigned NStages = (STAGES > MAX_STAGES) ? MAX_STAGES : STAGES;
  localparam int unsigned K       = APPROX_LSB;
  localparam int unsigned Cw      = chunk_w(WIDTH, APPROX_LSB, NStages);

  logic             advance;
  logic [MAX_W-1:0] a_ext, b_ext, lo_mask, lo_exact;
  stage_t           head, head_x;
  stage_t           pipe [NStages+1];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Exact mode resolves the low field with a real K-bit add ahead of the first chunk.
  always_comb begin
    a_ext    = MAX_W'(in_a);
    b_ext    = MAX_W'(in_b);
    lo_mask  = low_mask(K);
    lo_exact = (a_ext & lo_mask) + (b_ext & lo_mask);

    head       = '0;
    head.valid = in_valid;
    head.exact = in_exact;
    head.a_rem = a_ext >> K;
    head.b_rem = b_ext >> K;
    if (in_exact) begin
      head.carry    = lo_exact[K];
      head.sum_part = lo_exact & lo_mask;
    end else begin
      head.carry    = est_carry(a_ext, b_ext, K);
      head.sum_part = approx_low(a_ext, b_ext, K);
    end

    head_x          = head;
    head_x.exact    = 1'b1;
    head_x.carry    = lo_exact[K];
    head_x.sum_part = lo_exact & lo_mask;
  end

  assign pipe[0] = head;

  for (genvar g = 0; g < NStages; g++) begin : g_stage
    add_pipe_stage #(
      .Offset(K + g * Cw),
      .ChunkW(Cw)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (advance),
      .stage_i(pipe[g]),
      .stage_o(pipe[g+1])
    );
  end

  assign out_valid = pipe[NStages].valid;
  assign out_exact = pipe[NStages].exact;
  assign out_sum   = pipe[NStages].sum_part[WIDTH:0];

  logic unused_tail;
  assign unused_tail = ^{pipe[NStages].carry, pipe[NStages].sum_part[MAX_W-1:WIDTH+1],
                         pipe[NStages].a_rem, pipe[NStages].b_rem};

`ifdef ERRSTAT_EN
  stage_t shadow [NStages+1];

  assign shadow[0] = head_x;

  for (genvar g = 0; g < NStages; g++) begin : g_shadow
    add_pipe_stage #(
      .Offset(K + g * Cw),
      .ChunkW(Cw)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (advance),
      .stage_i(shadow[g]),
      .stage_o(shadow[g+1])
    );
  end

  logic             xfer;
  logic [WIDTH:0]   ref_sum, err_mag;
  logic [CNT_W-1:0] samples_d, samples_q, err_cnt_d, err_cnt_q;
  logic [WIDTH:0]   max_err_d, max_err_q;

  assign xfer    = out_valid && out_ready;
  assign ref_sum = shadow[NStages].sum_part[WIDTH:0];
  assign err_mag = (ref_sum >= out_sum) ? ref_sum - out_sum : out_sum - ref_sum;

  // Clear wins, but a same-cycle transfer is counted on top of the cleared values.
  always_comb begin
    samples_d = stat_clr ? '0 : samples_q;
    err_cnt_d = stat_clr ? '0 : err_cnt_q;
    max_err_d = stat_clr ? '0 : max_err_q;
    if (xfer) begin
      if (samples_d != '1) samples_d = samples_d + CNT_W'(1);
      if (err_mag != '0 && err_cnt_d != '1) err_cnt_d = err_cnt_d + CNT_W'(1);
      if (err_mag > max_err_d) max_err_d = err_mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples_q <= '0;
      err_cnt_q <= '0;
      max_err_q <= '0;
    end else begin
      samples_q <= samples_d;
      err_cnt_q <= err_cnt_d;
      max_err_q <= max_err_d;
    end
  end

  assign stat_samples = samples_q;
  assign stat_err_cnt = err_cnt_q;
  assign stat_max_err = max_err_q;

  logic unused_shadow;
  assign unused_shadow = ^{shadow[NStages].valid, shadow[NStages].exact, shadow[NStages].carry,
                           shadow[NStages].sum_part[MAX_W-1:WIDTH+1],
                           shadow[NStages].a_rem, shadow[NStages].b_rem};
`else
  logic unused_head_x;
  assign unused_head_x = ^head_x;
`endif

endmodule

// File: tb/tb_add_approx_pipe.sv
// Directed bench for add_approx_pipe (WIDTH=8, APPROX_LSB=4, STAGES=2); statistics
// checks apply when ERRSTAT_EN is defined.
module tb_add_approx_pipe;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_exact;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid, out_ready, out_exact;
  logic [WIDTH:0]   out_sum;
`ifdef ERRSTAT_EN
  logic             stat_clr;
  logic [15:0]      stat_samples, stat_err_cnt;
  logic [WIDTH:0]   stat_max_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_approx_pipe #(
    .WIDTH     (WIDTH),
    .APPROX_LSB(4),
    .STAGES    (2),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_exact    (in_exact),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_exact   (out_exact)
`ifdef ERRSTAT_EN
    ,
    .stat_clr    (stat_clr),
    .stat_samples(stat_samples),
    .stat_err_cnt(stat_err_cnt),
    .stat_max_err(stat_max_err)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ex;
    logic [8:0] exp_sum;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: even low bits from a, odd from b, carry estimated from bit 3.
  function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b,
                                         input logic ex);
    logic [8:0] r;
    logic       cin;
    if (ex) return {1'b0, a} + {1'b0, b};
    r = '0;
    for (int i = 0; i < 4; i++) r[i[3:0]] = (i % 2 == 0) ? a[i[2:0]] : b[i[2:0]];
    cin = a[3] & b[3];
    r[8:4] = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, cin};
    return r;
  endfunction

  task automatic send_one(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic ex, input logic [8:0] exp_sum);
    @(posedge clk); #1;
    in_a = a; in_b = b; in_exact = ex; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, " valid after 1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, " valid after 2"}, 32'(out_valid), 32'd1);
    check({name, " sum"}, 32'(out_sum), 32'(exp_sum));
    check({name, " exact echo"}, 32'(out_exact), 32'(ex));
  endtask

  vec_t       vecs [4];
  logic [7:0] sa [16];
  logic [7:0] sb [16];
  logic       sx [16];
  logic [8:0] se [16];
  vec_t       st [4];
  logic       exp_rdy [5];
  logic       exp_ov [5];
  int         idx, got;
  logic       accept;

  initial begin
    vecs[0] = '{a: 8'h37, b: 8'h29, ex: 1'b0, exp_sum: 9'h05D};
    vecs[1] = '{a: 8'h37, b: 8'h29, ex: 1'b1, exp_sum: 9'h060};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, ex: 1'b0, exp_sum: 9'h1FF};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, ex: 1'b1, exp_sum: 9'h1FE};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0; out_ready = 1'b1;
`ifdef ERRSTAT_EN
    stat_clr = 1'b0;
`endif
    #11;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_sum", 32'(out_sum), 32'd0);
    check("reset out_exact", 32'(out_exact), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 32'(in_ready), 32'd1);

    // Single transactions, approx and exact.
    for (int i = 0; i < 4; i++) send_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                                         vecs[i].ex, vecs[i].exp_sum);
    @(posedge clk); #1;
`ifdef ERRSTAT_EN
    check("stats samples", 32'(stat_samples), 32'd4);
    check("stats err_cnt", 32'(stat_err_cnt), 32'd2);
    check("stats max_err", 32'(stat_max_err), 32'd3);
`endif

    // Back-to-back stream, one result per cycle at latency 2.
    for (int i = 0; i < 16; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
      sx[i] = 1'($urandom_range(0, 1));
      se[i] = ref_sum(sa[i], sb[i], sx[i]);
    end
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      if (c < 16) begin
        in_a = sa[c]; in_b = sb[c]; in_exact = sx[c]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 2) begin
        check($sformatf("stream fill %0d", c), 32'(out_valid), 32'd0);
      end else begin
        check($sformatf("stream valid %0d", c - 2), 32'(out_valid), 32'd1);
        check($sformatf("stream sum %0d", c - 2), 32'(out_sum), 32'(se[c-2]));
        check($sformatf("stream exact %0d", c - 2), 32'(out_exact), 32'(sx[c-2]));
      end
    end
    @(posedge clk); #1;

    // Backpressure: 5 stalled cycles offering 4 items, then drain in order.
    st[0] = '{a: 8'h12, b: 8'h34, ex: 1'b0, exp_sum: 9'h0};
    st[1] = '{a: 8'hA5, b: 8'h5A, ex: 1'b1, exp_sum: 9'h0};
    st[2] = '{a: 8'h88, b: 8'h88, ex: 1'b0, exp_sum: 9'h0};
    st[3] = '{a: 8'h0F, b: 8'hF1, ex: 1'b1, exp_sum: 9'h0};
    for (int i = 0; i < 4; i++) st[i].exp_sum = ref_sum(st[i].a, st[i].b, st[i].ex);
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idx = 0; got = 0; accept = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (accept) idx++;
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_a = st[idx].a; in_b = st[idx].b; in_exact = st[idx].ex;
      end
      @(negedge clk);
      accept = in_valid & in_ready;
      check($sformatf("stall in_ready %0d", c), 32'(in_ready), 32'(exp_rdy[c]));
      check($sformatf("stall out_valid %0d", c), 32'(out_valid), 32'(exp_ov[c]));
      if (c >= 2) check($sformatf("stall hold %0d", c), 32'(out_sum), 32'(st[0].exp_sum));
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (accept) idx++;
      out_ready = 1'b1;
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_a = st[idx].a; in_b = st[idx].b; in_exact = st[idx].ex;
      end
      @(negedge clk);
      accept = in_valid & in_ready;
      if (out_valid) begin
        if (got < 4) check($sformatf("drain sum %0d", got), 32'(out_sum), 32'(st[got].exp_sum));
        got++;
      end
    end
    check("drain count", 32'(got), 32'd4);
    check("drain accepted", 32'(idx), 32'd4);

    // Asynchronous reset with two items in flight.
    @(posedge clk); #1;
    in_a = 8'h11; in_b = 8'h22; in_exact = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 8'h44; in_b = 8'h08;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight before reset", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid async", 32'(out_valid), 32'd0);
    check("reset out_sum async", 32'(out_sum), 32'd0);
`ifdef ERRSTAT_EN
    check("reset samples", 32'(stat_samples), 32'd0);
    check("reset err_cnt", 32'(stat_err_cnt), 32'd0);
    check("reset max_err", 32'(stat_max_err), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    send_one("post reset", 8'h37, 8'h29, 1'b0, 9'h05D);

`ifdef ERRSTAT_EN
    // Clear coinciding with a transfer whose error is 5.
    send_one("err5", 8'h00, 8'h05, 1'b0, 9'h000);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("clr samples", 32'(stat_samples), 32'd1);
    check("clr err_cnt", 32'(stat_err_cnt), 32'd1);
    check("clr max_err", 32'(stat_max_err), 32'd5);

    // Saturation.
    in_a = 8'h00; in_b = 8'h05; in_exact = 1'b0; in_valid = 1'b1;
    repeat (65539) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sat samples", 32'(stat_samples), 32'hFFFF);
    check("sat err_cnt", 32'(stat_err_cnt), 32'hFFFF);
    check("sat max_err", 32'(stat_max_err), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
